// File: rtl/fetch_pkg.sv
// Shared types and line geometry for the instruction fetch controller.
// The state enum is also used by the bench to check the reset state.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 2;
  localparam int LINE_BYTES     = 16;

  function automatic logic is_last_word(input logic [OFFSET_W-1:0] idx);
    return idx == OFFSET_W'(WORDS_PER_LINE - 1);
  endfunction

endpackage

// File: rtl/bin_counter_load.sv
// Generic binary up-counter with synchronous load and synchronous active-high reset.
// Wraps modulo 2^WIDTH; ld has priority over en.
module bin_counter_load #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Line-based instruction fetch: requests 16-byte lines from the I-cache and streams
// their four words into the fetch queue. Define FETCH_PERF_EN to add perf counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    ic_req_valid,
  output logic [ADDR_WIDTH-1:0]   ic_req_addr,
  input  logic                    ic_req_ready,
  input  logic                    ic_rsp_valid,
  input  logic [4*DATA_WIDTH-1:0] ic_rsp_data,
  output logic                    fq_push,
  output logic [DATA_WIDTH-1:0]   fq_data,
  input  logic                    fq_full,
  output logic                    fq_flush,
  output logic [1:0]              fq_offset,
`ifdef FETCH_PERF_EN
  output logic [31:0]             perf_lines,
  output logic [31:0]             perf_stalls,
`endif
  output logic [2:0]              dbg_state
);

  // Handshake: a cache request transfers on a cycle where ic_req_valid && ic_req_ready;
  // once raised, valid and addr hold until that cycle unless a redirect retargets them.
  // The cache answers each accepted request with exactly one ic_rsp_valid pulse.

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_line;
  logic [OFFSET_W-1:0]   index;
  logic [DATA_WIDTH-1:0] line_buf [WORDS_PER_LINE];

  logic flush_now;
  logic push_now;
  logic req_fire;
  logic line_done;
  logic unused_low_bits;

  assign redirect_line   = {redirect_pc[ADDR_WIDTH-1:4], 4'b0000};
  assign unused_low_bits = ^redirect_pc[1:0];

  // Redirects are ignored in IDLE; reset masks every strobe so nothing leaks out.
  assign flush_now = redirect_valid && (state != ST_IDLE) && !reset;
  assign push_now  = (state == ST_PUSH) && !fq_full && !flush_now && !reset;
  assign req_fire  = (state == ST_REQ) && ic_req_ready && !reset;
  assign line_done = push_now && is_last_word(index);

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin : next_state_logic
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        // A request accepted in the redirect cycle still owes us a response.
        if (flush_now) begin
          state_next = req_fire ? ST_DRAIN : ST_REQ;
        end else if (req_fire) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_now) begin
          state_next = ic_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (ic_rsp_valid) begin
          state_next = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (flush_now || line_done) begin
          state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Further redirects only move pc; leave once the stale response is swallowed.
        if (ic_rsp_valid) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (reset) begin
      pc    <= RESET_PC;
      index <= '0;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        line_buf[w] <= '0;
      end
    end else begin
      if (flush_now) begin
        pc <= redirect_line;
      end else if (line_done) begin
        pc <= pc + ADDR_WIDTH'(LINE_BYTES);
      end

      if ((state == ST_WAIT) && ic_rsp_valid && !flush_now) begin
        index <= '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          line_buf[w] <= ic_rsp_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (push_now) begin
        index <= index + 1'b1;
      end
    end
  end

  always_comb begin : output_logic
    ic_req_valid = (state == ST_REQ) && !reset;
    ic_req_addr  = ic_req_valid ? pc : '0;
    fq_push      = push_now;
    fq_data      = ((state == ST_PUSH) && !reset) ? line_buf[index] : '0;
    fq_flush     = flush_now;
    fq_offset    = flush_now ? redirect_pc[3:2] : 2'b00;
    dbg_state    = state;
  end

`ifdef FETCH_PERF_EN
  logic stall_now;

  // Stalls count every PUSH cycle the queue is full, redirect or not.
  assign stall_now = (state == ST_PUSH) && fq_full && !reset;

  bin_counter_load #(.WIDTH(32)) u_perf_lines (
    .clk    (clk),
    .reset  (reset),
    .en     (line_done),
    .ld     (1'b0),
    .ld_val (32'd0),
    .count  (perf_lines)
  );

  bin_counter_load #(.WIDTH(32)) u_perf_stalls (
    .clk    (clk),
    .reset  (reset),
    .en     (stall_now),
    .ld     (1'b0),
    .ld_val (32'd0),
    .count  (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic, checked
// against a line-level model of requests, pushed words and flushes.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0100;

  // Clock / reset and DUT connections.
  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          ic_req_valid;
  logic [31:0]   ic_req_addr;
  logic          ic_req_ready;
  logic          ic_rsp_valid;
  logic [127:0]  ic_rsp_data;
  logic          fq_push;
  logic [31:0]   fq_data;
  logic          fq_full;
  logic          fq_flush;
  logic [1:0]    fq_offset;
  logic [2:0]    dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_lines;
  logic [31:0]   perf_stalls;
`endif

  fetch_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_rsp_valid   (ic_rsp_valid),
    .ic_rsp_data    (ic_rsp_data),
    .fq_push        (fq_push),
    .fq_data        (fq_data),
    .fq_full        (fq_full),
    .fq_flush       (fq_flush),
    .fq_offset      (fq_offset),
`ifdef FETCH_PERF_EN
    .perf_lines     (perf_lines),
    .perf_stalls    (perf_stalls),
`endif
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state.
  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        pending;
  logic        stale;
  logic [31:0] pend_addr;
  int          rsp_wait;
  int          rsp_lat_cfg;
  logic        m_idle;
  int          m_lines;
  int          m_stalls;
  int          n_push;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_push;
  logic        s_flush;
  logic [1:0]  s_offset;

  logic        rv;
  logic [31:0] rpc;
  int          base;

  function automatic logic [31:0] word_of(input logic [31:0] a, input int i);
    logic [1:0] w;
    w = 2'(i);
    return {a[31:4], w, 2'b10} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = word_of(a, i);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle of stimulus, checks against the model, then model update.
  task automatic tick(input logic t_rv, input logic [31:0] t_rpc, input logic full, input logic rdy);
    logic rsp_now;
    logic exp_rv;
    logic exp_push;
    logic accepted;
    @(negedge clk);
    redirect_valid = t_rv;
    redirect_pc    = t_rpc;
    fq_full        = full;
    ic_req_ready   = rdy;
    rsp_now        = pending && (rsp_wait == 0);
    ic_rsp_valid   = rsp_now;
    ic_rsp_data    = rsp_now ? line_of(pend_addr) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    s_req_valid = ic_req_valid;
    s_req_addr  = ic_req_addr;
    s_push      = fq_push;
    s_flush     = fq_flush;
    s_offset    = fq_offset;
`ifdef FETCH_PERF_EN
    chk("perf_lines", perf_lines, 32'(m_lines));
    chk("perf_stalls", perf_stalls, 32'(m_stalls));
`endif
    exp_rv = !m_idle && !pending && (exp_q.size() == 0);
    chk("req_valid", ic_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", ic_req_addr, exp_addr);
    chk("flush", fq_flush, t_rv);
    chk("offset", fq_offset, t_rv ? t_rpc[3:2] : 2'b00);
    exp_push = (exp_q.size() != 0) && !full && !t_rv;
    chk("push", fq_push, exp_push);
    if ((exp_q.size() != 0) && full) m_stalls++;
    if (fq_push && (exp_q.size() != 0)) begin
      chk("data", fq_data, exp_q[0]);
      void'(exp_q.pop_front());
      n_push++;
      if (exp_q.size() == 0) m_lines++;
    end
    accepted = ic_req_valid && rdy;
    if (accepted) chk("one_outstanding", pending, 1'b0);
    if (rsp_now) begin
      pending = 1'b0;
      if (!stale && !t_rv) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(word_of(pend_addr, i));
        exp_addr = pend_addr + 32'd16;
      end
    end else if (pending) begin
      rsp_wait--;
    end
    if (accepted) begin
      pending   = 1'b1;
      stale     = 1'b0;
      pend_addr = ic_req_addr;
      rsp_wait  = rsp_lat_cfg;
    end
    if (t_rv) begin
      exp_q.delete();
      exp_addr = {t_rpc[31:4], 4'b0000};
      if (pending) stale = 1'b1;
    end
    m_idle = 1'b0;
  endtask

  // Reset driver: holds reset with redirect asserted and checks every output stays quiet.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
      fq_full        = 1'b0;
      ic_req_ready   = 1'b1;
      ic_rsp_valid   = 1'b0;
      #1;
      chk("rst_req_valid", ic_req_valid, 1'b0);
      chk("rst_req_addr", ic_req_addr, 32'd0);
      chk("rst_push", fq_push, 1'b0);
      chk("rst_data", fq_data, 32'd0);
      chk("rst_flush", fq_flush, 1'b0);
      chk("rst_offset", fq_offset, 2'b00);
      chk("rst_state", dbg_state, 64'(ST_IDLE));
`ifdef FETCH_PERF_EN
      chk("rst_perf_lines", perf_lines, 32'd0);
      chk("rst_perf_stalls", perf_stalls, 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    ic_req_ready   = 1'b0;
    pending        = 1'b0;
    stale          = 1'b0;
    exp_q.delete();
    exp_addr       = RPC;
    m_idle         = 1'b1;
    m_lines        = 0;
    m_stalls       = 0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    n_push         = 0;
    rsp_lat_cfg    = 0;
    rsp_wait       = 0;
    pend_addr      = '0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ic_req_ready   = 1'b0;
    ic_rsp_valid   = 1'b0;
    ic_rsp_data    = '0;
    fq_full        = 1'b0;
    do_reset(3);

    // First line from RESET_PC, four back-to-back words, then the next line.
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("idle_no_req", s_req_valid, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    chk("first_req_valid", s_req_valid, 1'b1);
    chk("first_req_addr", s_req_addr, 32'h100);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'd0, 1'b0, 1'b0);
      chk("consec_push", s_push, 1'b1);
    end
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    chk("next_line_addr", s_req_addr, 32'h110);

    // Queue full for three cycles after word 1.
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_no_push", s_push, 1'b0);
    end
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("after_stall_push", s_push, 1'b1);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_stalls_3", perf_stalls, 32'd3);
`endif

    // Redirect to 0x20C while pushing.
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 32'h20C, 1'b0, 1'b0);
    chk("push_redir_flush", s_flush, 1'b1);
    chk("push_redir_offset", s_offset, 2'd3);
    chk("push_redir_nopush", s_push, 1'b0);
    rsp_lat_cfg = 3;
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    chk("push_redir_next", s_req_addr, 32'h200);

    // Redirect to 0x404 while the 0x200 response is outstanding.
    tick(1'b1, 32'h404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      chk("drain_no_req", s_req_valid, 1'b0);
    end
    rsp_lat_cfg = 0;
    base = n_push;
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    chk("drain_next_addr", s_req_addr, 32'h400);
    for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("drain_words", 64'(n_push - base), 64'd4);

    // Last line of the address space wraps to zero.
    tick(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_req_addr", s_req_addr, 32'hFFFF_FFF0);
    for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_next_addr", s_req_addr, 32'h0);

    // Reset in the middle of a line restarts at RESET_PC.
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("pre_reset_push", s_push, 1'b1);
    do_reset(2);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("restart_idle", s_req_valid, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("restart_addr", s_req_addr, RPC);

    // Randomized traffic: cache latency, ready, queue backpressure, redirects, resets.
    base = n_push;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        rsp_lat_cfg = $urandom_range(0, 3);
        rv  = !m_idle && ($urandom_range(0, 15) == 0);
        rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        tick(rv, rpc, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end
    end
    chk("random_progress", 64'(n_push - base > 100), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
